// File: rtl/i2c_write_scheduler.sv
// I2C write master: round-robin grants NUM_REQ requesters, each served as a
// START / address / two data bytes / STOP sequence followed by an idle gap.
module i2c_write_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int BIT_CLKS = 1000,
  parameter int GAP_CLKS = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*7-1:0]  req_addr,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    done,
  output logic                  nack_err,
  output logic                  busy,
  output logic                  SCL,
  inout  wire                   SDA
);
  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXC = (BIT_CLKS > GAP_CLKS) ? BIT_CLKS : GAP_CLKS;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] Q1       = CW'(BIT_CLKS / 4);
  localparam logic [CW-1:0] HALF     = CW'(BIT_CLKS / 2);
  localparam logic [CW-1:0] Q3       = CW'((3 * BIT_CLKS) / 4);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, GAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic            byte_idx;
  logic [7:0]      shreg;
  logic [15:0]     data_reg;
  logic [IW-1:0]   rr_ptr;
  logic            err;
  logic            ack_bit;
  logic            sda_low;
  logic            sda_meta;
  logic            sda_sync;
  logic            period_end;
  logic            phase_high;
  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;
  logic [6:0]      addr_arr [NUM_REQ];
  logic [15:0]     data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[7*i +: 7];
    assign data_arr[i] = req_data[16*i +: 16];
  end

  assign SDA        = sda_low ? 1'b0 : 1'bz;
  assign busy       = (state != IDLE);
  assign period_end = (cnt == BIT_LAST);
  assign phase_high = (cnt >= Q1) && (cnt < Q3);

  // Descending scan so the candidate nearest after rr_ptr is the one left standing.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      sda_meta <= SDA;
      sda_sync <= sda_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
      shreg    <= '0;
      data_reg <= '0;
      rr_ptr   <= IW'(NUM_REQ - 1);
      err      <= 1'b0;
      ack_bit  <= 1'b0;
      req_ack  <= '0;
      done     <= '0;
      nack_err <= 1'b0;
      SCL      <= 1'b1;
      sda_low  <= 1'b0;
    end else begin
      req_ack  <= '0;
      done     <= '0;
      nack_err <= 1'b0;

      // Bus pins are registered from the current state and period position.
      case (state)
        START: begin
          SCL     <= (cnt < HALF);
          sda_low <= 1'b1;
        end
        ADDR, DATA: begin
          SCL     <= phase_high;
          sda_low <= ~shreg[7];
        end
        ADDR_ACK, DATA_ACK: begin
          SCL     <= phase_high;
          sda_low <= 1'b0;
        end
        STOP: begin
          SCL     <= (cnt >= Q1);
          sda_low <= (cnt < Q3);
        end
        default: begin
          SCL     <= 1'b1;
          sda_low <= 1'b0;
        end
      endcase

      case (state)
        IDLE: begin
          if (grant_found) begin
            shreg              <= {addr_arr[grant_idx], 1'b0};
            data_reg           <= data_arr[grant_idx];
            req_ack[grant_idx] <= 1'b1;
            rr_ptr             <= grant_idx;
            cnt                <= '0;
            state              <= START;
          end
        end
        START: begin
          if (period_end) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= ADDR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ADDR, DATA: begin
          if (period_end) begin
            cnt   <= '0;
            shreg <= {shreg[6:0], 1'b0};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (cnt == HALF) ack_bit <= sda_sync;
          // The second data byte is never acknowledged by the slaves.
          if (period_end) begin
            cnt <= '0;
            if (state == DATA_ACK && byte_idx) begin
              state <= STOP;
            end else if (ack_bit) begin
              err   <= 1'b1;
              state <= STOP;
            end else begin
              shreg    <= (state == ADDR_ACK) ? data_reg[15:8] : data_reg[7:0];
              byte_idx <= (state == DATA_ACK);
              state    <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (period_end) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            done[rr_ptr] <= 1'b1;
            nack_err     <= err;
            err          <= 1'b0;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_write_scheduler.sv
// Bench for i2c_write_scheduler: a bus-level slave model plus a round-robin
// reference model predict grants, completion timing, NACKs and received data.
module tb_i2c_write_scheduler;
  localparam int NUM_REQ     = 2;
  localparam int BIT_CLKS    = 40;
  localparam int GAP_CLKS    = 60;
  localparam int B           = BIT_CLKS;
  localparam int OK_CYCLES   = 29 * BIT_CLKS + GAP_CLKS;
  localparam int NACK_CYCLES = 11 * BIT_CLKS + GAP_CLKS;
  localparam int TRACE_LEN   = 29 * BIT_CLKS;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*7-1:0]  req_addr = '0;
  logic [NUM_REQ*16-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    done;
  logic                  nack_err;
  logic                  busy;
  logic                  scl;
  wire                   sda;
  logic                  slave_pull = 1'b0;

  assign sda = slave_pull ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_write_scheduler #(
    .NUM_REQ (NUM_REQ),
    .BIT_CLKS(BIT_CLKS),
    .GAP_CLKS(GAP_CLKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ack  (req_ack),
    .done     (done),
    .nack_err (nack_err),
    .busy     (busy),
    .SCL      (scl),
    .SDA      (sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Slave model: 7'h64 and 7'h65 acknowledge address and first data byte.
  bit         prev_scl = 1'b1, prev_sda = 1'b1;
  bit         sl_active = 1'b0, sl_ackph = 1'b0, sl_sel = 1'b0, stop_seen = 1'b0;
  int         sl_bits = 0, sl_byte = 0;
  logic [7:0] sl_shift = '0, sl_addr = '0, sl_hi = '0;
  logic [15:0] slave_data [2];
  int         rx_count = 0, stop_cyc = 0, last_gap = 0;
  bit         trace_arm = 1'b0;
  int         trace_pos = -1;
  logic       trace_scl [TRACE_LEN];
  logic       trace_sda [TRACE_LEN];

  always @(negedge clk) begin
    if (reset) begin
      sl_active  = 1'b0;
      sl_ackph   = 1'b0;
      slave_pull = 1'b0;
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
    end else begin
      if (scl && prev_scl && prev_sda && !sda) begin
        sl_active = 1'b1;
        sl_bits   = 0;
        sl_byte   = 0;
        sl_ackph  = 1'b0;
        if (stop_seen) last_gap = cyc - stop_cyc;
        if (trace_arm) begin
          trace_arm = 1'b0;
          trace_pos = 0;
        end
      end else if (scl && prev_scl && !prev_sda && sda) begin
        sl_active  = 1'b0;
        slave_pull = 1'b0;
        stop_seen  = 1'b1;
        stop_cyc   = cyc;
      end else if (sl_active && scl && !prev_scl) begin
        if (!sl_ackph) begin
          sl_shift = {sl_shift[6:0], sda};
          sl_bits++;
        end
      end else if (sl_active && !scl && prev_scl) begin
        if (sl_ackph) begin
          slave_pull = 1'b0;
          sl_ackph   = 1'b0;
          sl_bits    = 0;
          sl_byte++;
        end else if (sl_bits == 8) begin
          sl_ackph = 1'b1;
          if (sl_byte == 0) begin
            sl_addr    = sl_shift;
            sl_sel     = (sl_shift[7:1] == 7'h64 || sl_shift[7:1] == 7'h65) && !sl_shift[0];
            slave_pull = sl_sel;
          end else if (sl_byte == 1) begin
            sl_hi      = sl_shift;
            slave_pull = sl_sel;
          end else begin
            if (sl_sel && sl_byte == 2) begin
              slave_data[sl_addr[1]] = {sl_hi, sl_shift};
              rx_count++;
            end
            slave_pull = 1'b0;
          end
        end
      end
      if (trace_pos >= 0 && trace_pos < TRACE_LEN) begin
        trace_scl[trace_pos] = scl;
        trace_sda[trace_pos] = sda;
        trace_pos++;
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  // Reference model: requester fields and round-robin pointer.
  logic [6:0]  r_addr [NUM_REQ];
  logic [15:0] r_data [NUM_REQ];
  int model_ptr = NUM_REQ - 1;
  int last_grant = -1;

  function automatic int pickModel(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic applyStimulus(input int idx, input logic [6:0] addr, input logic [15:0] data);
    r_addr[idx] = addr;
    r_data[idx] = data;
    req_addr[idx*7 +: 7]   = addr;
    req_data[idx*16 +: 16] = data;
    req_valid[idx] = 1'b1;
  endtask

  task automatic doReset();
    req_valid = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ptr = NUM_REQ - 1;
  endtask

  function automatic logic [6:0] randAddr();
    logic [6:0] a;
    case ($urandom_range(0, 3))
      0: a = 7'h64;
      1: a = 7'h65;
      2: begin
        a = 7'($urandom_range(0, 127));
        while (a == 7'h64 || a == 7'h65) a = 7'($urandom_range(0, 127));
      end
      default: a = 7'h65;
    endcase
    return a;
  endfunction

  task automatic serveOne();
    int exp_idx, waited, ack_cyc, lat, rx_before;
    logic [6:0]  exp_addr;
    logic [15:0] exp_data;
    bit exp_nack, stray;
    exp_idx = pickModel(req_valid, model_ptr);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ack == '0 && waited < 8);
    checkOutput("ack_latency", waited, 1);
    checkOutput("ack_vector", req_ack, 32'(1) << exp_idx);
    if (req_ack == '0) return;
    ack_cyc   = cyc;
    exp_addr  = r_addr[exp_idx];
    exp_data  = r_data[exp_idx];
    exp_nack  = !(exp_addr == 7'h64 || exp_addr == 7'h65);
    rx_before = rx_count;
    req_valid[exp_idx] = 1'b0;
    model_ptr  = exp_idx;
    last_grant = exp_idx;
    lat   = exp_nack ? NACK_CYCLES : OK_CYCLES;
    stray = 1'b0;
    waited = 0;
    @(negedge clk);
    while (done == '0 && waited < lat + 20) begin
      if (!busy || req_ack != '0) stray = 1'b1;
      @(negedge clk);
      waited++;
    end
    checkOutput("done_latency", cyc - ack_cyc, lat);
    checkOutput("done_vector", done, 32'(1) << exp_idx);
    checkOutput("nack_err", nack_err, exp_nack);
    checkOutput("busy_hold", stray, 0);
    if (!exp_nack) checkOutput("slave_data", slave_data[exp_addr[0]], exp_data);
    checkOutput("rx_count", rx_count - rx_before, exp_nack ? 0 : 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited, unstable, any;
    logic [7:0]  abyte;
    logic [15:0] keep;
    int off [6];
    bit exp_scl [6];
    slave_data[0] = '0;
    slave_data[1] = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_scl", scl, 1);
    checkOutput("rst_sda", sda, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ack", req_ack, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_nack", nack_err, 0);
    reset = 1'b0;

    // Single traced transaction to the LED slave.
    trace_arm = 1'b1;
    applyStimulus(0, 7'h64, 16'hA55A);
    serveOne();
    checkOutput("start_sda", trace_sda[0], 0);
    checkOutput("start_scl_hi", trace_scl[B/2-1], 1);
    checkOutput("start_scl_lo", trace_scl[B/2], 0);
    off = '{0, B/4-1, B/4, 3*B/4-1, 3*B/4, B-1};
    exp_scl = '{0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) checkOutput("bit_scl", trace_scl[B + off[i]], exp_scl[i]);
    abyte = {7'h64, 1'b0};
    unstable = 0;
    for (int p = 1; p <= 8; p++) begin
      checkOutput("addr_bit", trace_sda[p*B], abyte[8-p]);
      for (int c = 1; c < 3*B/4; c++)
        if (trace_sda[p*B + c] !== trace_sda[p*B]) unstable++;
    end
    checkOutput("addr_stable", unstable, 0);
    checkOutput("addr_acked", trace_sda[9*B + B/2], 0);
    checkOutput("stop_scl_lo", trace_scl[28*B + B/4 - 1], 0);
    checkOutput("stop_scl_hi", trace_scl[28*B + B - 1], 1);
    checkOutput("stop_sda_lo", trace_sda[28*B + 3*B/4 - 1], 0);
    checkOutput("stop_sda_hi", trace_sda[28*B + 3*B/4], 1);

    // Address NACK.
    trace_arm = 1'b1;
    applyStimulus(0, 7'h12, 16'h1234);
    serveOne();
    checkOutput("nack_released", trace_sda[9*B + B/2], 1);
    checkOutput("nack_stop_lo", trace_sda[10*B], 0);
    checkOutput("nack_stop_hi", trace_sda[10*B + 3*B/4], 1);
    checkOutput("nack_stop_scl", trace_scl[10*B + B - 1], 1);

    // Reset in the middle of the first data byte.
    keep = slave_data[0];
    applyStimulus(0, 7'h64, 16'h3C3C);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ack == '0 && waited < 8);
    checkOutput("mid_ack", req_ack, 1);
    req_valid = '0;
    repeat (15*BIT_CLKS - 1) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_scl", scl, 1);
    checkOutput("mid_rst_sda", sda, 1);
    checkOutput("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    model_ptr = NUM_REQ - 1;
    checkOutput("mid_no_write", slave_data[0], keep);
    applyStimulus(1, 7'h65, 16'hC3A5);
    serveOne();

    // Contention: both held, re-armed after own grant for the first two.
    doReset();
    applyStimulus(0, 7'h64, 16'($urandom));
    applyStimulus(1, 7'h65, 16'($urandom));
    for (int k = 0; k < 4; k++) begin
      serveOne();
      checkOutput("rr_order", last_grant, k % 2);
      if (k < 2) applyStimulus(last_grant, r_addr[last_grant], 16'($urandom));
    end

    // Back-to-back on requester 0.
    applyStimulus(0, 7'h64, 16'h1111);
    serveOne();
    applyStimulus(0, 7'h64, 16'h0F0F);
    serveOne();
    checkOutput("gap_respected", last_gap >= GAP_CLKS, 1);

    // Randomized mix of requesters, addresses and payloads.
    for (int r = 0; r < 14; r++) begin
      any = 0;
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) applyStimulus(i, randAddr(), 16'($urandom));
      if (req_valid == '0) begin
        any = $urandom_range(0, NUM_REQ - 1);
        applyStimulus(any, randAddr(), 16'($urandom));
      end
      serveOne();
    end
    while (req_valid != '0) serveOne();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_write_scheduler.md
Name: i2c_write_scheduler

Overview:
- Bus-owning I2C master that serializes 2-byte write transactions from NUM_REQ requesters (LED, FND, CPU-side peripherals) onto one shared SCL/SDA pair.
- Round-robin arbitration; the winner's address and data are captured at grant.
- Generates START/address/data/STOP with fixed BIT_CLKS-per-bit timing, matching the team's fixed-timing I2C slaves (sample at mid-bit, ACK held low almost the whole ACK bit).
- Reports per-requester completion and NACK errors.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- BIT_CLKS, 1000, clk cycles per bit period, including START and STOP; must be divisible by 4.
- GAP_CLKS, 1000, idle cycles after STOP before the next START.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  request pending, one bit per requester; held until req_ack
- req_addr  input  NUM_REQ*7  7-bit slave address per requester; requester i uses bits [7i+6:7i]
- req_data  input  NUM_REQ*16  payload per requester; requester i uses bits [16i+15:16i]; byte [15:8] is sent first
- req_ack  output  NUM_REQ  one-cycle pulse when requester i is granted and its fields are captured
- done  output  NUM_REQ  one-cycle pulse when requester i's transaction has fully ended (after GAP)
- nack_err  output  1  one-cycle pulse together with done when the transaction was NACKed
- busy  output  1  high in every state except IDLE
- SCL  output  1  bus clock, push-pull
- SDA  inout  1  bus data; master drives only 0 or z, never 1

Behaviour:
- Reset values:
  - state = IDLE.
  - SCL = 1, SDA = z.
  - req_ack, done, nack_err = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - All counters = 0.
- Reset mid-transaction aborts immediately to the reset values. The slave recovers via its own STOP/IDLE path.
- SDA input passes through a 2-flop synchronizer before any sampling.
- Bit timing within each period, cnt = 0..BIT_CLKS-1:
  - SCL = 0 for cnt < BIT_CLKS/4.
  - SCL = 1 for BIT_CLKS/4 ≤ cnt < 3*BIT_CLKS/4.
  - SCL = 0 for the rest of the period.
  - SDA output updates at cnt = 0 only.
  - Sampling happens at cnt = BIT_CLKS/2.
- States:
  - IDLE:
    - Scan req_valid starting at rr_ptr+1 (mod NUM_REQ) and grant the first set bit.
    - On grant: capture {addr, 1'b0} into the shift register, capture the data, pulse req_ack[i], set rr_ptr = i, go to START.
    - No valid request: stay in IDLE.
  - START, one period: SDA = 0 from cnt 0; SCL = 1 for the first half, 0 for the second half.
  - ADDR: 8 bits, MSB first, R/W bit = 0. A 1 bit is sent as z, a 0 bit as driven 0.
  - ADDR_ACK: SDA = z; sample at mid-bit.
    - Sampled 0: go to DATA with byte index 0.
    - Sampled 1: set err flag, go to STOP.
  - DATA: 8 bits, MSB first.
  - DATA_ACK: SDA = z; sample at mid-bit.
    - Byte 0: sampled 1 sets err and goes to STOP; sampled 0 goes to DATA with byte index 1.
    - Byte 1: the sampled value is ignored (the slave does not drive it); go to STOP.
  - STOP, one period:
    - SDA = 0 for cnt < 3*BIT_CLKS/4, then z.
    - SCL follows the normal bit timing, except it stays high from BIT_CLKS/4 to the end of the period.
  - GAP: SCL = 1, SDA = z for GAP_CLKS cycles.
    - On the last cycle: pulse done[i]; pulse nack_err if err; clear err; go to IDLE.
- Latency from grant to done:
  - Success: 29*BIT_CLKS + GAP_CLKS. This is 1 START + 9 address + 18 data + 1 STOP periods, i.e. 30000 cycles at defaults.
  - Address NACK: 11*BIT_CLKS + GAP_CLKS.
- Requests and grants:
  - req_valid changes during busy are ignored until IDLE.
  - Simultaneous requests are served alternately by the round-robin order.
  - A requester re-asserting immediately after its own done waits behind any other pending requester.
- Counters: bit counter 0..7, byte index 0..1, cycle counter wide enough for max(BIT_CLKS, GAP_CLKS). No counter wraps within a state.

Test Plan:
- Single request: req_valid=01, addr0=7'h64, data0=16'hA55A, LED slave at 7'h64 on the bus.
  - req_ack[0] pulses 1 cycle after valid.
  - Slave led_data = 16'hA55A and rx_done pulses.
  - done[0] pulses at grant + 30000 cycles; nack_err = 0.
- Address NACK: addr0 = 7'h12, no matching slave.
  - SDA released during the ADDR_ACK bit, then STOP.
  - done[0] and nack_err pulse together at grant + 12000 cycles.
- Contention: req_valid=11 held, addr0=7'h64 and addr1=7'h65, two slaves on the bus.
  - Grants occur in order 0, 1, 0, 1, with req_ack pulses one transaction apart.
  - Both slaves latch their own data each time.
- Bus waveform check, one bit period:
  - SCL low 0–249, high 250–749, low 750–999.
  - SDA transitions only at cnt 0, except in START and STOP.
  - SDA is never driven to 1.
- Reset mid-data (assert at grant + 15000 cycles):
  - SCL = 1, SDA = z, busy = 0 on the next edge.
  - A new request afterwards completes normally with correct data.
- Back-to-back requests, same requester: req_valid[0] re-asserted the cycle after done[0].
  - Next START occurs at least GAP_CLKS after STOP.
  - Slave returns to IDLE and accepts the second write 16'h0F0F.
